interp_sched: RTL and testbench

Frame sequencer for the 2x2 averaging interpolation datapath (`interpolate`) in the camera pipeline. It accepts a raw 12-bit pixel stream and a per-frame start command, and counts column/row position within a `ROW_LENGTH` x `ROWS` frame. It forwards pixels to the datapath, qualifies the datapath's 1-cycle-late result so only interior windows (row ≥ 1, col ≥ 1) reach the output, and adds start-of-frame and end-of-line markers. It reports busy/done status to the frame-level controller.

---
 rtl/interp_pkg.sv | 14 +
 rtl/interp_scan_cnt.sv | 39 +++
 rtl/interp_sched.sv | 121 ++++++++++++
 tb/tb_interp_sched.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/interp_pkg.sv
// Shared types and constants for the interpolation frame sequencer.
package interp_pkg;

    localparam int DEFAULT_DATA_W = 12;
    localparam int STATS_W        = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } sched_state_t;

endpackage

// File: rtl/interp_scan_cnt.sv
// Column/row position counter for a ROW_LENGTH x ROWS frame, advancing on accepted pixels.
module interp_scan_cnt #(
    parameter int ROW_LENGTH = 640,
    parameter int ROWS       = 480,
    localparam int COL_W     = $clog2(ROW_LENGTH),
    localparam int ROW_W     = $clog2(ROWS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             advance,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             col_wrap,
    output logic             frame_end
);

    assign col_wrap  = (col == COL_W'(ROW_LENGTH - 1));
    assign frame_end = col_wrap && (row == ROW_W'(ROWS - 1));

    // Clear wins over advance so a new frame always starts at the origin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (clear) begin
            col <= '0;
            row <= '0;
        end else if (advance) begin
            if (col_wrap) begin
                col <= '0;
                row <= frame_end ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

endmodule

// File: rtl/interp_sched.sv
// Frame sequencer for the 2x2 averaging interpolation datapath.
// Defining INTERP_SCHED_STATS_EN adds o_frame_cnt / o_drop_cnt statistics outputs.
import interp_pkg::*;

module interp_sched #(
    parameter int ROW_LENGTH = 640,
    parameter int ROWS       = 480,
    parameter int DATA_W     = DEFAULT_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic              i_pix_valid,
    input  logic [DATA_W-1:0] i_pix_data,
    output logic              o_dp_valid,
    output logic [DATA_W-1:0] o_dp_data,
    input  logic [DATA_W-1:0] i_dp_data,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_sof,
    output logic              o_eol,
    output logic              o_busy,
    output logic              o_done
`ifdef INTERP_SCHED_STATS_EN
    ,
    output logic [STATS_W-1:0] o_frame_cnt,
    output logic [STATS_W-1:0] o_drop_cnt
`endif
);

    localparam int COL_W = $clog2(ROW_LENGTH);
    localparam int ROW_W = $clog2(ROWS);

    sched_state_t     state_q, state_d;
    logic [COL_W-1:0] col, q_col;
    logic [ROW_W-1:0] row, q_row;
    logic             q_vld, done_q, out_vld;
    logic             streaming, accept, cnt_clear, col_wrap, frame_end;

    assign streaming = (state_q == FILL) || (state_q == RUN);
    assign accept    = streaming && i_pix_valid && !i_abort;
    assign cnt_clear = i_abort || ((state_q == IDLE) && i_start);

    interp_scan_cnt #(
        .ROW_LENGTH(ROW_LENGTH),
        .ROWS      (ROWS)
    ) u_scan (
        .clk      (i_clk),
        .rst      (i_rst),
        .clear    (cnt_clear),
        .advance  (accept),
        .col      (col),
        .row      (row),
        .col_wrap (col_wrap),
        .frame_end(frame_end)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_start) state_d = FILL;
            FILL:    if (accept && col_wrap) state_d = RUN;
            RUN:     if (accept && frame_end) state_d = FLUSH;
            FLUSH:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (i_abort) state_d = IDLE;
    end

    // Qualifier tracks the datapath's one-cycle latency; row 0 never reaches RUN.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            q_vld  <= 1'b0;
            q_col  <= '0;
            q_row  <= '0;
            done_q <= 1'b0;
        end else begin
            q_vld  <= accept && (state_q == RUN) && (col != '0);
            q_col  <= col;
            q_row  <= row;
            done_q <= (state_q == FLUSH) && !i_abort;
        end
    end

    assign out_vld    = q_vld && !i_abort;
    assign o_dp_valid = streaming && i_pix_valid;
    assign o_dp_data  = streaming ? i_pix_data : '0;
    assign o_valid    = out_vld;
    assign o_data     = out_vld ? i_dp_data : '0;
    assign o_sof      = out_vld && (q_row == ROW_W'(1)) && (q_col == COL_W'(1));
    assign o_eol      = out_vld && (q_col == COL_W'(ROW_LENGTH - 1));
    assign o_busy     = (state_q != IDLE);
    assign o_done     = done_q;

`ifdef INTERP_SCHED_STATS_EN
    logic [STATS_W-1:0] frame_cnt, drop_cnt;

    // Frame count wraps; drop count saturates at all-ones.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            frame_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            if (done_q)
                frame_cnt <= frame_cnt + STATS_W'(1);
            if ((state_q == IDLE) && i_pix_valid && (drop_cnt != '1))
                drop_cnt <= drop_cnt + STATS_W'(1);
        end
    end

    assign o_frame_cnt = frame_cnt;
    assign o_drop_cnt  = drop_cnt;
`endif

endmodule

// File: tb/tb_interp_sched.sv
// Scoreboard bench for interp_sched on a 4x4 frame with a behavioural 2x2 averaging datapath.
`timescale 1ns/1ps
module tb_interp_sched;
    import interp_pkg::*;

    localparam int RL = 4;
    localparam int RW = 4;
    localparam int DW = 12;

    typedef struct {
        int data;
        int sof;
        int eol;
    } exp_t;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_start = 1'b0;
    logic          i_abort = 1'b0;
    logic          i_pix_valid = 1'b0;
    logic [DW-1:0] i_pix_data = '0;
    logic          o_dp_valid;
    logic [DW-1:0] o_dp_data;
    logic [DW-1:0] i_dp_data = '0;
    logic          o_valid, o_sof, o_eol, o_busy, o_done;
    logic [DW-1:0] o_data;
`ifdef INTERP_SCHED_STATS_EN
    logic [STATS_W-1:0] o_frame_cnt, o_drop_cnt;
`endif

    int   checks = 0;
    int   errors = 0;
    int   doneCount = 0;
    int   expFrames = 0;
    int   expDrops = 0;
    exp_t expQ[$];
    logic modelClear = 1'b0;

    always #5 i_clk = ~i_clk;

    interp_sched #(.ROW_LENGTH(RL), .ROWS(RW), .DATA_W(DW)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .i_abort    (i_abort),
        .i_pix_valid(i_pix_valid),
        .i_pix_data (i_pix_data),
        .o_dp_valid (o_dp_valid),
        .o_dp_data  (o_dp_data),
        .i_dp_data  (i_dp_data),
        .o_valid    (o_valid),
        .o_data     (o_data),
        .o_sof      (o_sof),
        .o_eol      (o_eol),
        .o_busy     (o_busy),
        .o_done     (o_done)
`ifdef INTERP_SCHED_STATS_EN
        ,
        .o_frame_cnt(o_frame_cnt),
        .o_drop_cnt (o_drop_cnt)
`endif
    );

    // Stand-in for the interpolate datapath: registered average of the 2x2 window.
    logic [DW-1:0] rowPrev [RL];
    logic [DW-1:0] rowCur [RL];
    int            mCol = 0;
    always @(posedge i_clk) begin
        if (modelClear) begin
            mCol = 0;
        end else if (o_dp_valid) begin
            if (mCol > 0)
                i_dp_data <= DW'((int'(rowPrev[mCol-1]) + int'(rowPrev[mCol]) +
                                  int'(rowCur[mCol-1]) + int'(o_dp_data)) >> 2);
            rowCur[mCol] = o_dp_data;
            if (mCol == RL - 1) begin
                rowPrev = rowCur;
                mCol = 0;
            end else begin
                mCol++;
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an output.
    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (o_valid) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_output: got data %0d, expected no output", o_data);
                end else begin
                    exp_t e;
                    e = expQ.pop_front();
                    checkOutput("o_data", int'(o_data), e.data);
                    checkOutput("o_sof", int'(o_sof), e.sof);
                    checkOutput("o_eol", int'(o_eol), e.eol);
                end
            end else begin
                checkOutput("o_data_idle", int'(o_data), 0);
                checkOutput("o_sof_idle", int'(o_sof), 0);
                checkOutput("o_eol_idle", int'(o_eol), 0);
            end
            if (o_done) doneCount++;
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input int data, input logic start);
        i_pix_valid = valid;
        i_pix_data  = DW'(data);
        i_start     = start;
        tick();
        i_start = 1'b0;
    endtask

    task automatic startFrame();
        i_start    = 1'b1;
        modelClear = 1'b1;
        tick();
        i_start    = 1'b0;
        modelClear = 1'b0;
        checkOutput("busy_after_start", int'(o_busy), 1);
    endtask

    task automatic driveFrame(input int nPix, input bit gaps, input int startAt);
        for (int idx = 0; idx < nPix; idx++) begin
            int r, c;
            r = idx / RL;
            c = idx % RL;
            if (gaps) applyStimulus(1'b0, 4095, 1'b0);
            if (r >= 1 && c >= 1)
                expQ.push_back('{data: 4*r + c - 3, sof: int'(r == 1 && c == 1), eol: int'(c == RL - 1)});
            applyStimulus(1'b1, r*RL + c, logic'(idx == startAt));
        end
        i_pix_valid = 1'b0;
    endtask

    // Called in the FLUSH cycle; returns in the o_done cycle.
    task automatic checkFrameEnd();
        checkOutput("flush_busy", int'(o_busy), 1);
        checkOutput("flush_done", int'(o_done), 0);
        tick();
        checkOutput("done_pulse", int'(o_done), 1);
        checkOutput("done_busy", int'(o_busy), 0);
        expFrames++;
    endtask

    initial begin
        int doneBefore;
        #2;
        checkOutput("rst_valid", int'(o_valid), 0);
        checkOutput("rst_data", int'(o_data), 0);
        checkOutput("rst_busy", int'(o_busy), 0);
        checkOutput("rst_done", int'(o_done), 0);
        checkOutput("rst_dp_valid", int'(o_dp_valid), 0);
        checkOutput("rst_dp_data", int'(o_dp_data), 0);
        tick();
        tick();
        i_rst = 1'b0;
        tick();

        $display("[TB] continuous frame");
        startFrame();
        driveFrame(RL*RW, 1'b0, -1);
        checkFrameEnd();
        tick();
        checkOutput("done_single", int'(o_done), 0);

        $display("[TB] frame with input gaps");
        startFrame();
        driveFrame(RL*RW, 1'b1, -1);
        checkFrameEnd();
        tick();

        $display("[TB] pixels dropped in idle");
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, 100 + k, 1'b0);
        expDrops += 3;
        i_pix_valid = 1'b0;
        tick();
        checkOutput("idle_busy", int'(o_busy), 0);
`ifdef INTERP_SCHED_STATS_EN
        checkOutput("drop_cnt", int'(o_drop_cnt), expDrops);
`endif
        startFrame();
        driveFrame(RL*RW, 1'b0, -1);
        checkFrameEnd();
        tick();

        $display("[TB] abort after seven pixels");
        doneBefore = doneCount;
        startFrame();
        driveFrame(7, 1'b0, -1);
        tick();
        i_abort = 1'b1;
        applyStimulus(1'b1, 77, 1'b0);
        i_abort = 1'b0;
        checkOutput("abort_busy", int'(o_busy), 0);
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, 200 + k, 1'b0);
        expDrops += 3;
        i_pix_valid = 1'b0;
        tick();
        checkOutput("abort_no_done", doneCount, doneBefore);
        checkOutput("abort_queue", expQ.size(), 0);
        startFrame();
        driveFrame(RL*RW, 1'b0, -1);
        checkFrameEnd();
        tick();

        $display("[TB] start mid-frame and start with abort");
        startFrame();
        driveFrame(RL*RW, 1'b0, 8);
        checkFrameEnd();
        tick();
        i_start = 1'b1;
        i_abort = 1'b1;
        tick();
        i_start = 1'b0;
        i_abort = 1'b0;
        checkOutput("start_abort_busy", int'(o_busy), 0);
        tick();
        checkOutput("start_abort_busy2", int'(o_busy), 0);

        $display("[TB] async reset mid-run");
        startFrame();
        driveFrame(6, 1'b0, -1);
        i_pix_valid = 1'b1;
        i_pix_data  = DW'(6);
        #1;
        i_rst = 1'b1;
        #1;
        checkOutput("arst_valid", int'(o_valid), 0);
        checkOutput("arst_data", int'(o_data), 0);
        checkOutput("arst_busy", int'(o_busy), 0);
        checkOutput("arst_dp_valid", int'(o_dp_valid), 0);
        checkOutput("arst_dp_data", int'(o_dp_data), 0);
        expQ.delete();
        expFrames = 0;
        expDrops  = 0;
        i_pix_valid = 1'b0;
        tick();
        i_rst = 1'b0;
        tick();

        $display("[TB] back-to-back frames");
        startFrame();
        driveFrame(RL*RW, 1'b0, -1);
        checkFrameEnd();
        startFrame();
        driveFrame(RL*RW, 1'b0, -1);
        checkFrameEnd();
        tick();
`ifdef INTERP_SCHED_STATS_EN
        checkOutput("frame_cnt", int'(o_frame_cnt), expFrames);
        checkOutput("drop_cnt_end", int'(o_drop_cnt), expDrops);
`endif
        tick();
        tick();
        checkOutput("queue_empty", expQ.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
